// File: rtl/csr_wq_pkg.sv
// Shared types and sizing helpers for the CSR write queue.
package csr_wq_pkg;

  typedef enum logic {
    CSR_WQ_IDLE = 1'b0,
    CSR_WQ_WAIT = 1'b1
  } csr_wq_state_e;

  localparam int CSR_WQ_TIMEOUT_DEFAULT = 1024;

  // Pointer width for a power-of-two depth (depth >= 2).
  function automatic int csr_wq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy counts 0..depth inclusive, so it needs one more code than the pointer.
  function automatic int csr_wq_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/csr_wq_fifo.sv
// Circular buffer behind csr_write_queue: storage, pointers, occupancy, full/empty
// and detection of pushes dropped because the buffer is full.
module csr_wq_fifo
  import csr_wq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                i_push,
  input  logic [WIDTH-1:0]    i_wr_data,
  input  logic                i_pop,
  output logic [WIDTH-1:0]    o_head,
  output logic [DEPTH_LOG2:0] o_level,
  output logic                o_empty,
  output logic                o_drop,
  output logic                o_next_not_full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = csr_wq_ptr_w(DEPTH);
  localparam int LVL_W = csr_wq_lvl_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;

  // A full buffer refuses the push even when a pop frees a slot in the same cycle.
  assign w_full          = (r_level == LVL_W'(DEPTH));
  assign o_empty         = (r_level == '0);
  assign w_wr_en         = i_push && !w_full;
  assign w_rd_en         = i_pop && !o_empty;
  assign o_drop          = i_push && w_full;
  assign o_head          = r_mem[r_rd_ptr];
  assign o_level         = r_level;
  assign o_next_not_full = (w_level_nxt < LVL_W'(DEPTH));

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // NOTE: storage has no reset; emptiness is tracked by r_level, so stale words are never read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
    end
  end

endmodule

// File: rtl/csr_write_queue.sv
// Buffers SPAM-bus CSR writes and issues them one at a time to the CSR async-write
// synchronizer. Optional WAIT-state watchdog enabled by defining CSR_WQ_TIMEOUT_EN.
module csr_write_queue
  import csr_wq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2,
  parameter int TIMEOUT    = CSR_WQ_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                in_strobe,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  input  logic                ovf_clr,
  output logic                overflow,
  output logic                out_strobe,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_wait,
  input  logic                out_done_strobe,
  output logic                busy,
  output logic [DEPTH_LOG2:0] level
`ifdef CSR_WQ_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  csr_wq_state_e    r_state;
  csr_wq_state_e    w_state_nxt;
  logic             w_issue;
  logic [WIDTH-1:0] w_head;
  logic             w_empty;
  logic             w_drop;
  logic             w_next_not_full;
  logic             r_out_strobe;
  logic [WIDTH-1:0] r_out_data;
  logic             r_in_ready;
  logic             r_overflow;

`ifdef CSR_WQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;
  logic             w_timeout_hit;
`endif

  csr_wq_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk             (clk),
    .rst_b           (rst_b),
    .i_push          (in_strobe),
    .i_wr_data       (in_data),
    .i_pop           (w_issue),
    .o_head          (w_head),
    .o_level         (level),
    .o_empty         (w_empty),
    .o_drop          (w_drop),
    .o_next_not_full (w_next_not_full)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= CSR_WQ_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
`ifdef CSR_WQ_TIMEOUT_EN
    w_timeout_hit = 1'b0;
`endif
    case (r_state)
      CSR_WQ_IDLE: begin
        if (!w_empty && !out_wait) begin
          w_issue     = 1'b1;
          w_state_nxt = CSR_WQ_WAIT;
        end
      end
      CSR_WQ_WAIT: begin
        // A completion in the terminal watchdog cycle still counts as a normal return.
        if (out_done_strobe) begin
          w_state_nxt = CSR_WQ_IDLE;
        end
`ifdef CSR_WQ_TIMEOUT_EN
        else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt   = CSR_WQ_IDLE;
          w_timeout_hit = 1'b1;
        end
`endif
      end
      default: w_state_nxt = CSR_WQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_out_strobe <= 1'b0;
      r_out_data   <= '0;
      r_in_ready   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_out_strobe <= w_issue;
      if (w_issue) r_out_data <= w_head;
      r_in_ready <= w_next_not_full;
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

`ifdef CSR_WQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_issue)                    r_wait_cnt <= '0;
      else if (r_state == CSR_WQ_WAIT) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  assign in_ready   = r_in_ready;
  assign overflow   = r_overflow;
  assign out_strobe = r_out_strobe;
  assign out_data   = r_out_data;
  assign busy       = (level != '0) || (r_state != CSR_WQ_IDLE);

endmodule

// File: tb/tb_csr_write_queue.sv
// Self-checking bench for csr_write_queue: directed scenarios plus randomized traffic
// against a queue-based reference model and a synchronizer stand-in.
module tb_csr_write_queue;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int NEVER      = -1;
`ifdef CSR_WQ_TIMEOUT_EN
  localparam int TIMEOUT    = 16;
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam int TIMEOUT    = 1024;
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        in_strobe = 1'b0;
  logic [31:0] in_data = '0;
  logic        ovf_clr = 1'b0;
  logic        out_wait = 1'b0;
  logic        out_done_strobe = 1'b0;
  logic        in_ready;
  logic        overflow;
  logic        out_strobe;
  logic [31:0] out_data;
  logic        busy;
  logic [2:0]  level;
`ifdef CSR_WQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  csr_write_queue #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .in_strobe       (in_strobe),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .ovf_clr         (ovf_clr),
    .overflow        (overflow),
    .out_strobe      (out_strobe),
    .out_data        (out_data),
    .out_wait        (out_wait),
    .out_done_strobe (out_done_strobe),
    .busy            (busy),
    .level           (level)
`ifdef CSR_WQ_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending writes as a queue, one in-flight flag, sticky flags.
  logic [31:0] m_q[$];
  logic [31:0] accepted[$];
  logic [31:0] issued[$];
  bit          m_wait, m_ovf, m_terr, m_strobe, m_ready;
  int          m_wcnt;
  logic [31:0] m_data;

  // Synchronizer stand-in.
  bit sync_pend, wait_en, spur_en;
  int sync_cnt;
  int done_lat = 5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    accepted.delete();
    m_wait = 0; m_ovf = 0; m_terr = 0; m_strobe = 0; m_ready = 0;
    m_wcnt = 0; m_data = '0;
    sync_pend = 0; sync_cnt = 0;
    out_done_strobe = 0; out_wait = 0;
  endtask

  task automatic model_edge();
    int  l;
    bit  pop, was_wait, dropped;
    l        = m_q.size();
    was_wait = m_wait;
    pop      = !m_wait && (l > 0) && !out_wait;
    dropped  = in_strobe && (l >= DEPTH);
    m_strobe = pop;
    if (pop) m_data = m_q.pop_front();
    if (in_strobe && !dropped) begin
      m_q.push_back(in_data);
      accepted.push_back(in_data);
    end
    if (dropped)      m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (pop) begin
      m_wait = 1;
      m_wcnt = 0;
    end else if (was_wait) begin
      if (out_done_strobe) m_wait = 0;
      else if (TIMEOUT_ON && m_wcnt == TIMEOUT - 1) begin
        m_wait = 0;
        m_terr = 1;
      end else m_wcnt++;
    end
    m_ready = (m_q.size() < DEPTH);
  endtask

  task automatic compare();
    check("out_strobe", out_strobe, m_strobe);
    check("out_data", out_data, m_data);
    check("level", level, m_q.size());
    check("in_ready", in_ready, m_ready);
    check("overflow", overflow, m_ovf);
    check("busy", busy, (m_q.size() != 0) || m_wait);
`ifdef CSR_WQ_TIMEOUT_EN
    check("timeout_err", timeout_err, m_terr);
`endif
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later, then inputs for the next cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (out_strobe) begin
      issued.push_back(out_data);
      if (accepted.size() == 0) check("spurious_strobe", 1, 0);
      else check("order", out_data, accepted.pop_front());
      sync_pend = 1;
      sync_cnt  = done_lat;
    end
    out_done_strobe = 0;
    if (sync_pend && done_lat != NEVER) begin
      sync_cnt--;
      if (sync_cnt <= 0) begin
        out_done_strobe = 1;
        sync_pend       = 0;
      end
    end else if (!sync_pend && spur_en) begin
      out_done_strobe = ($urandom_range(15) == 0);
    end
    out_wait = wait_en ? ($urandom_range(3) == 0) : 1'b0;
  endtask

  task automatic drain(input string tag);
    in_strobe = 0;
    ovf_clr   = 0;
    wait_en   = 0;
    spur_en   = 0;
    for (int i = 0; i < 300 && (busy || sync_pend); i++) step();
    check(tag, busy, 0);
  endtask

  task automatic push(input logic [31:0] d);
    in_strobe = 1;
    in_data   = d;
    step();
    in_strobe = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen, dp, saw_bad;
    int n;

    // Asynchronous reset with no clock edge yet.
    #1 rst_b = 0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_strobe", out_strobe, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1 rst_b = 1;
    model_reset();
    step();
    check("rst_ready_rise", in_ready, 1);
    step();

    // Single write, done after 5 cycles.
    done_lat = 5;
    issued.delete();
    push(32'hDEAD_BEEF);
    check("t1_no_early", out_strobe, 0);
    step();
    check("t1_strobe", out_strobe, 1);
    check("t1_data", out_data, 32'hDEAD_BEEF);
    step();
    check("t1_pulse", out_strobe, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      dp = out_done_strobe;
      step();
      if (dp) begin
        check("t1_busy_fall", busy, 0);
        seen = 1;
      end
    end
    check("t1_done_seen", seen, 1);

    // Back-to-back pushes.
    done_lat = 3;
    issued.delete();
    n = 0;
    in_strobe = 1;
    for (int i = 1; i <= 3; i++) begin
      in_data = i;
      step();
      if (int'(level) > n) n = int'(level);
    end
    in_strobe = 0;
    drain("t2_drain");
    check("t2_level_peak", n, 2);
    check("t2_count", issued.size(), 3);
    for (int i = 0; i < 3 && i < issued.size(); i++) check("t2_order", issued[i], i + 1);

    // Stalled synchronizer: fill, drop, clear.
    done_lat = NEVER;
    issued.delete();
    in_strobe = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h100 + i;
      step();
    end
    check("t3_full_ready", in_ready, 0);
    check("t3_full_level", level, 4);
    in_data = 32'hBAD;
    step();
    in_strobe = 0;
    check("t3_ovf_set", overflow, 1);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    check("t3_ovf_clr", overflow, 0);
    done_lat = 2;
    sync_cnt = 2;
    drain("t3_drain");
    saw_bad = 0;
    foreach (issued[i]) if (issued[i] == 32'hBAD) saw_bad = 1;
    check("t3_no_dropped", saw_bad, 0);
    check("t3_count", issued.size(), 5);

    // Pointer wrap: 10 writes through 4 entries.
    done_lat = 1;
    issued.delete();
    for (int i = 0; i < 10; i++) begin
      push(32'h10 + i);
      step();
    end
    drain("t4_drain");
    check("t4_count", issued.size(), 10);
    for (int i = 0; i < 10 && i < issued.size(); i++) check("t4_order", issued[i], 32'h10 + i);

`ifdef CSR_WQ_TIMEOUT_EN
    // Done never returned: watchdog releases WAIT.
    done_lat = NEVER;
    in_strobe = 1;
    in_data = 32'hA5A5_0001;
    step();
    in_data = 32'hA5A5_0002;
    step();
    in_strobe = 0;
    check("t6_issue", out_strobe, 1);
    n = 0;
    while (!timeout_err && n < 40) begin
      step();
      n++;
    end
    check("t6_timeout_cycle", n, 16);
    step();
    check("t6_next_issue", out_strobe, 1);
    check("t6_next_data", out_data, 32'hA5A5_0002);
    drain("t6_drain");
`endif

    // Reset while waiting with two entries queued.
    done_lat = NEVER;
    in_strobe = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h200 + i;
      step();
    end
    in_strobe = 0;
    step();
    #3 rst_b = 0;
    #1;
    check("t5_out_data", out_data, 0);
    check("t5_level", level, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_out_strobe", out_strobe, 0);
    model_reset();
    @(posedge clk);
    #1 rst_b = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_strobe) n++;
    end
    check("t5_no_strobe", n, 0);
    check("t5_level_after", level, 0);

    // Randomized traffic.
    wait_en = 1;
    spur_en = 1;
    for (int i = 0; i < 400; i++) begin
      done_lat  = $urandom_range(6, 1);
      in_strobe = $urandom_range(1);
      in_data   = $urandom;
      ovf_clr   = ($urandom_range(7) == 0);
      step();
    end
    done_lat = 2;
    drain("rand_drain");
    check("rand_all_issued", accepted.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
